// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and frame-reader state, plus a width helper that never returns 0.
package sdram_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } sdram_rw_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_e;

    // Counter widths stay at least one bit even for degenerate 1-pixel dimensions.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: a write is visible on rd_dat/rd_vld the next cycle.
// wr_vld is honoured when not full or when a read happens in the same cycle; the caller provides credit.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_vld,
    input  logic [DATA_WIDTH-1:0]        wr_dat,
    output logic                         rd_vld,
    input  logic                         rd_rdy,
    output logic [DATA_WIDTH-1:0]        rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_rd;
    logic                  do_wr;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_rd  = rd_rdy && rd_vld;
    // At full, the head slot is freed by this cycle's read and can take the write.
    assign do_wr  = wr_vld && ((count != CW'(DEPTH)) || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_frame_reader.sv
// Reads one H_ACTIVE x V_ACTIVE frame from SDRAM and streams it out; first command one cycle after start, response-to-pixel one cycle.
// Commands are credit-limited so the response FIFO never overflows; downstream stalls throttle command issue, never responses.
module sdram_frame_reader
    import sdram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 24,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sdram_cmd_valid,
    input  logic                  sdram_cmd_ready,
    output logic                  sdram_cmd_rw,
    output logic [ADDR_WIDTH-1:0] sdram_cmd_addr,
    input  logic                  sdram_resp_valid,
    output logic                  sdram_resp_ready,
    input  logic [DATA_WIDTH-1:0] sdram_cmd_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int PIX_W = clog2_min1(TOTAL);
    localparam int X_W   = clog2_min1(H_ACTIVE);
    localparam int Y_W   = clog2_min1(V_ACTIVE);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    reader_state_e         state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [PIX_W-1:0]      cmd_idx;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      fifo_count;
    logic [X_W-1:0]        x_cnt;
    logic [Y_W-1:0]        y_cnt;
    logic [CNT_W:0]        occ_next;
    logic                  fifo_wr;
    logic                  cmd_acc;
    logic                  pix_acc;
    logic                  last_cmd;
    logic                  last_x;
    logic                  last_pix;
    logic                  credit_ok;

    assign sdram_cmd_rw     = READ;
    assign sdram_resp_ready = busy;
    assign fifo_wr          = sdram_resp_valid && busy;
    assign cmd_acc          = sdram_cmd_valid && sdram_cmd_ready;
    assign pix_acc          = m_axis_tvalid && m_axis_tready;
    assign last_cmd         = (cmd_idx == PIX_W'(TOTAL - 1));
    assign last_x           = (x_cnt == X_W'(H_ACTIVE - 1));
    assign last_pix         = last_x && (y_cnt == Y_W'(V_ACTIVE - 1));
    assign m_axis_tuser     = m_axis_tvalid && (x_cnt == '0) && (y_cnt == '0);
    assign m_axis_tlast     = m_axis_tvalid && last_x;

    // Slots committed after this edge: a response only moves a word from
    // "outstanding" into the FIFO, so it leaves the total unchanged.
    always_comb begin
        occ_next  = {1'b0, outstanding} + {1'b0, fifo_count};
        occ_next  = occ_next + (CNT_W+1)'(cmd_acc) - (CNT_W+1)'(pix_acc);
        credit_ok = (occ_next < (CNT_W+1)'(FIFO_DEPTH));
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk    (sdram_clk),
        .rst_n  (sdram_rstn),
        .wr_vld (fifo_wr),
        .wr_dat (sdram_cmd_rdata),
        .rd_vld (m_axis_tvalid),
        .rd_rdy (m_axis_tready),
        .rd_dat (m_axis_tdata),
        .count  (fifo_count)
    );

    always_ff @(posedge sdram_clk or negedge sdram_rstn) begin
        if (!sdram_rstn) begin
            state           <= IDLE;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            sdram_cmd_valid <= 1'b0;
            sdram_cmd_addr  <= '0;
            base_q          <= '0;
            cmd_idx         <= '0;
            outstanding     <= '0;
            x_cnt           <= '0;
            y_cnt           <= '0;
        end else begin
            frame_done <= 1'b0;

            if (cmd_acc && !fifo_wr) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (fifo_wr && !cmd_acc) begin
                outstanding <= outstanding - CNT_W'(1);
            end

            if (pix_acc) begin
                x_cnt <= last_x ? '0 : x_cnt + X_W'(1);
                if (last_x) begin
                    y_cnt <= last_pix ? '0 : y_cnt + Y_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q          <= base_addr;
                        cmd_idx         <= '0;
                        sdram_cmd_addr  <= base_addr;
                        sdram_cmd_valid <= 1'b1;
                        busy            <= 1'b1;
                        outstanding     <= '0;
                        x_cnt           <= '0;
                        y_cnt           <= '0;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    if (cmd_acc && last_cmd) begin
                        sdram_cmd_valid <= 1'b0;
                        state           <= DRAIN;
                    end else if (cmd_acc || !sdram_cmd_valid) begin
                        // cmd_idx is always the most recently presented index here.
                        if (credit_ok) begin
                            sdram_cmd_valid <= 1'b1;
                            cmd_idx         <= cmd_idx + PIX_W'(1);
                            sdram_cmd_addr  <= base_q + ADDR_WIDTH'(cmd_idx + PIX_W'(1));
                        end else begin
                            sdram_cmd_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (pix_acc && last_pix) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed-plus-random bench: SDRAM controller model, AXI sink and frame reference model for sdram_frame_reader.
module tb_sdram_frame_reader;

    localparam int DW = 16;
    localparam int AW = 24;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int D  = 4;
    localparam int N  = H * V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, frame_done;
    logic          cmd_valid, cmd_rw;
    logic          cmd_ready = 1'b0;
    logic [AW-1:0] cmd_addr;
    logic          resp_valid = 1'b0;
    logic          resp_ready;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] tdata;
    logic          tvalid, tuser, tlast;
    logic          tready = 1'b0;

    sdram_frame_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (D)
    ) dut (
        .sdram_clk        (clk),
        .sdram_rstn       (rst_n),
        .start            (start),
        .base_addr        (base_addr),
        .busy             (busy),
        .frame_done       (frame_done),
        .sdram_cmd_valid  (cmd_valid),
        .sdram_cmd_ready  (cmd_ready),
        .sdram_cmd_rw     (cmd_rw),
        .sdram_cmd_addr   (cmd_addr),
        .sdram_resp_valid (resp_valid),
        .sdram_resp_ready (resp_ready),
        .sdram_cmd_rdata  (rdata),
        .m_axis_tdata     (tdata),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tuser     (tuser),
        .m_axis_tlast     (tlast)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Written by the stimulus only.
    logic [AW-1:0] exp_base = '0;
    int            cr_mode = 0;   // 0: cmd_ready high, 1: random
    int            tr_mode = 0;   // 0: tready high, 1: random, 2: held low
    int            lat_min = 2;
    int            lat_max = 2;
    logic          stray_req = 1'b0;

    // Written by the monitor only.
    int            cmd_n = 0;
    int            pix_n = 0;
    int            done_n = 0;
    int            cyc = 0;
    int            last_hs_cyc = 0;
    logic [AW-1:0] aq[$];
    int            dq[$];
    logic          prev_cmd_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_ax_stall = 1'b0;
    logic [DW-1:0] prev_tdata = '0;
    logic          prev_tuser = 1'b0;
    logic          prev_tlast = 1'b0;
    logic          prev_tvalid = 1'b0;
    logic          prev_resp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Controller, sink and reference model all act at the falling edge.
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        cyc++;
        resp_valid = 1'b0;
        if (!rst_n) begin
            aq.delete();
            dq.delete();
            cmd_n = 0;
            pix_n = 0;
            cmd_ready = 1'b0;
            tready = 1'b0;
            prev_cmd_stall = 1'b0;
            prev_ax_stall = 1'b0;
            prev_tvalid = 1'b0;
            prev_resp = 1'b0;
            check("rst_busy", 32'(busy), 0);
            check("rst_frame_done", 32'(frame_done), 0);
            check("rst_cmd_valid", 32'(cmd_valid), 0);
            check("rst_cmd_addr", 32'(cmd_addr), 0);
            check("rst_resp_ready", 32'(resp_ready), 0);
            check("rst_tvalid", 32'(tvalid), 0);
            check("rst_tdata", 32'(tdata), 0);
            check("rst_tuser", 32'(tuser), 0);
            check("rst_tlast", 32'(tlast), 0);
        end else begin
            // Stream side
            if (prev_ax_stall) begin
                check("axis_hold_valid", 32'(tvalid), 1);
                check("axis_hold_data", 32'(tdata), 32'(prev_tdata));
                check("axis_hold_user", 32'(tuser), 32'(prev_tuser));
                check("axis_hold_last", 32'(tlast), 32'(prev_tlast));
            end
            if (prev_resp && !prev_tvalid) check("resp_to_tvalid", 32'(tvalid), 1);
            tready = (tr_mode == 0) ? 1'b1 : (tr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (tvalid && tready) begin
                ea = exp_base + AW'(pix_n);
                check("pix_in_frame", 32'(pix_n < N), 1);
                check("tdata", 32'(tdata), 32'(ea[DW-1:0]));
                check("tuser", 32'(tuser), 32'(pix_n == 0));
                check("tlast", 32'(tlast), 32'((pix_n % H) == H - 1));
                pix_n++;
                last_hs_cyc = cyc;
            end
            prev_ax_stall = tvalid && !tready;
            prev_tdata = tdata;
            prev_tuser = tuser;
            prev_tlast = tlast;
            prev_tvalid = tvalid;

            // Command side
            if (prev_cmd_stall) begin
                check("cmd_hold_valid", 32'(cmd_valid), 1);
                check("cmd_hold_addr", 32'(cmd_addr), 32'(prev_addr));
            end
            cmd_ready = (cr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cmd_valid && cmd_ready) begin
                ea = exp_base + AW'(cmd_n);
                check("cmd_in_frame", 32'(cmd_n < N), 1);
                check("cmd_addr", 32'(cmd_addr), 32'(ea));
                check("cmd_rw", 32'(cmd_rw), 0);
                aq.push_back(cmd_addr);
                dq.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
                cmd_n++;
                check("credit", 32'((cmd_n - pix_n) <= D), 1);
            end
            prev_cmd_stall = cmd_valid && !cmd_ready;
            prev_addr = cmd_addr;

            // Responses come back in order, data = low address bits.
            prev_resp = 1'b0;
            if (dq.size() != 0 && cyc >= dq[0]) begin
                resp_valid = 1'b1;
                rdata = aq[0][DW-1:0];
                void'(aq.pop_front());
                void'(dq.pop_front());
                prev_resp = 1'b1;
            end else if (stray_req && !busy) begin
                resp_valid = 1'b1;
                rdata = 16'hDEAD;
            end

            if (frame_done) begin
                done_n++;
                check("done_pix_count", 32'(pix_n), N);
                check("done_cmd_count", 32'(cmd_n), N);
                check("done_busy_low", 32'(busy), 0);
                check("done_latency", 32'(cyc), 32'(last_hs_cyc + 1));
                cmd_n = 0;
                pix_n = 0;
            end
            check("resp_ready_busy", 32'(resp_ready), 32'(busy));
        end
    end

    task automatic kick(input logic [AW-1:0] b);
        @(negedge clk);
        exp_base = b;
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
        base_addr = AW'($urandom);
        check("first_cmd_valid", 32'(cmd_valid), 1);
        check("first_cmd_addr", 32'(cmd_addr), 32'(b));
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frame_done_count", 32'(done_n), 32'(target));
    endtask

    task automatic wait_pix(input int n, input int budget);
        int k = 0;
        while (pix_n < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("pix_reached", 32'(pix_n >= n), 1);
    endtask

    initial begin
        int target;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Response while idle must be dropped.
        @(posedge clk); #1 stray_req = 1'b1;
        @(posedge clk); #1 stray_req = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_tvalid", 32'(tvalid), 0);
        check("idle_resp_ready", 32'(resp_ready), 0);

        // Basic frame, fixed 2-cycle read latency.
        target = done_n + 1;
        kick(24'h000100);
        wait_done(target, 200);

        // Downstream stalled for 20 cycles.
        tr_mode = 2;
        target = done_n + 1;
        kick(24'h000180);
        repeat (20) @(negedge clk);
        check("stall_cmds_bounded", 32'(cmd_n <= D), 1);
        check("stall_cmds_some", 32'(cmd_n > 0), 1);
        check("stall_no_pixels", 32'(pix_n), 0);
        check("stall_resp_ready", 32'(resp_ready), 1);
        check("stall_busy", 32'(busy), 1);
        tr_mode = 0;
        wait_done(target, 200);

        // Address wrap.
        target = done_n + 1;
        kick(24'hFFFFFE);
        wait_done(target, 200);

        // Second start during RUN is ignored.
        target = done_n + 1;
        kick(24'h000040);
        @(negedge clk);
        start = 1'b1;
        base_addr = 24'h000200;
        @(negedge clk);
        start = 1'b0;
        wait_done(target, 200);
        repeat (10) @(negedge clk);
        check("no_extra_frame", 32'(done_n), 32'(target));
        check("idle_after_frame", 32'(busy), 0);
        check("idle_cmd_valid", 32'(cmd_valid), 0);

        // Reset mid-frame, then a clean frame.
        target = done_n;
        kick(24'h000500);
        wait_pix(3, 200);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done_n), 32'(target));
        target = done_n + 1;
        kick(24'h000300);
        wait_done(target, 200);

        // Random handshakes and latencies over 10 frames.
        cr_mode = 1;
        tr_mode = 1;
        lat_min = 1;
        lat_max = 4;
        target = done_n;
        for (int f = 0; f < 10; f++) begin
            kick(AW'($urandom));
            wait_done(target + f + 1, 400);
        end
        check("random_frames", 32'(done_n - target), 10);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: observed no finish, required finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
